// File: rtl/regfile_pkg.sv
// Shared CPU definitions: data width, register index width and the register index type.
package regfile_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] regaddr_t;

endpackage

// File: rtl/regfile.sv
// Integer register file: x0 hardwired to zero, two operand read ports with optional
// write-first bypass, an unbypassed debug read port and a committed-write counter.
module regfile
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN   = regfile_pkg::XLEN,
    parameter bit          BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  regaddr_t        rs1_addr,
    input  regaddr_t        rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            we,
    input  regaddr_t        rd_addr,
    input  logic [XLEN-1:0] rd_data,
    input  regaddr_t        dbg_addr,
    output logic [XLEN-1:0] dbg_data,
    output logic [31:0]     wr_count
);

    // x0 has no storage; index 0 is decoded to zero on every read port.
    logic [XLEN-1:0] r_regs [1:NUM_REGS-1];
    logic [31:0]     r_wr_count;

    // Write targets a real register; rst is deliberately not included so that
    // forwarding stays visible during reset while storage is still protected.
    logic w_wr_hit;
    logic w_wr_commit;

    assign w_wr_hit    = we && (rd_addr != '0);
    assign w_wr_commit = w_wr_hit && !rst;

    // Stored value at addr, optionally replaced by the same-cycle write data.
    function automatic logic [XLEN-1:0] read_port(input regaddr_t addr, input logic byp);
        logic [XLEN-1:0] v;
        v = '0;
        if (addr != '0) begin
            v = r_regs[addr];
        end
        if (byp && w_wr_hit && (addr == rd_addr)) begin
            v = rd_data;
        end
        return v;
    endfunction

    // Combinational read ports; debug port always returns stored contents.
    always_comb begin
        rs1_data = read_port(rs1_addr, BYPASS);
        rs2_data = read_port(rs2_addr, BYPASS);
        dbg_data = read_port(dbg_addr, 1'b0);
    end

    // Register storage: reset clears everything and overrides a pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_commit) begin
            r_regs[rd_addr] <= rd_data;
        end
    end

    // Committed-write counter, wraps modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_count <= '0;
        end else if (w_wr_commit) begin
            r_wr_count <= r_wr_count + 32'd1;
        end
    end

    assign wr_count = r_wr_count;

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: one bypassing and one non-bypassing instance share stimulus.
module tb_regfile;

    import regfile_pkg::*;

    logic        clk;
    logic        rst;
    regaddr_t    rs1_addr;
    regaddr_t    rs2_addr;
    logic        we;
    regaddr_t    rd_addr;
    logic [31:0] rd_data;
    regaddr_t    dbg_addr;

    logic [31:0] b_rs1, b_rs2, b_dbg, b_cnt;
    logic [31:0] n_rs1, n_rs2, n_dbg, n_cnt;

    int total;
    int bad;

    regfile #(
        .XLEN  (32),
        .BYPASS(1'b1)
    ) u_byp (
        .clk     (clk),
        .rst     (rst),
        .rs1_addr(rs1_addr),
        .rs2_addr(rs2_addr),
        .rs1_data(b_rs1),
        .rs2_data(b_rs2),
        .we      (we),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .dbg_addr(dbg_addr),
        .dbg_data(b_dbg),
        .wr_count(b_cnt)
    );

    regfile #(
        .XLEN  (32),
        .BYPASS(1'b0)
    ) u_nobyp (
        .clk     (clk),
        .rst     (rst),
        .rs1_addr(rs1_addr),
        .rs2_addr(rs2_addr),
        .rs1_data(n_rs1),
        .rs2_data(n_rs2),
        .we      (we),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .dbg_addr(dbg_addr),
        .dbg_data(n_dbg),
        .wr_count(n_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are read 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        we       = 1'b0;
        rd_addr  = '0;
        rd_data  = '0;
        rs1_addr = '0;
        rs2_addr = '0;
        dbg_addr = '0;
        tick();
        rst = 1'b0;

        // Every register reads zero after reset on all three ports.
        for (int i = 1; i < 32; i++) begin
            rs1_addr = regaddr_t'(i);
            rs2_addr = regaddr_t'(i);
            dbg_addr = regaddr_t'(i);
            #1;
            check("rst_rs1", b_rs1, 32'h0);
            check("rst_rs2", b_rs2, 32'h0);
            check("rst_dbg", b_dbg, 32'h0);
            check("rst_rs1_nb", n_rs1, 32'h0);
        end
        check("rst_cnt", b_cnt, 32'd0);
        check("rst_cnt_nb", n_cnt, 32'd0);

        // Simple write, visible next cycle.
        we = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEAD_BEEF;
        tick();
        we = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd5;
        #1;
        check("wr5_rs1", b_rs1, 32'hDEAD_BEEF);
        check("wr5_rs2_nb", n_rs2, 32'hDEAD_BEEF);
        check("wr5_cnt", b_cnt, 32'd1);

        // Write to x0 is discarded and never forwarded.
        we = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFF_FFFF;
        rs1_addr = 5'd0; rs2_addr = 5'd0; dbg_addr = 5'd0;
        #1;
        check("x0_during_rs1", b_rs1, 32'h0);
        check("x0_during_rs2", b_rs2, 32'h0);
        tick();
        we = 1'b0;
        #1;
        check("x0_after_rs1", b_rs1, 32'h0);
        check("x0_after_dbg", b_dbg, 32'h0);
        check("x0_cnt", b_cnt, 32'd1);

        // Same-cycle forwarding versus stored value.
        we = 1'b1; rd_addr = 5'd7; rd_data = 32'h11;
        tick();
        we = 1'b1; rd_addr = 5'd7; rd_data = 32'h22;
        rs1_addr = 5'd7; rs2_addr = 5'd7; dbg_addr = 5'd7;
        #1;
        check("byp_rs1", b_rs1, 32'h22);
        check("byp_rs2", b_rs2, 32'h22);
        check("byp_dbg", b_dbg, 32'h11);
        check("nobyp_rs1", n_rs1, 32'h11);
        check("nobyp_rs2", n_rs2, 32'h11);
        check("nobyp_dbg", n_dbg, 32'h11);
        tick();
        we = 1'b0;
        #1;
        check("x7_rs1", b_rs1, 32'h22);
        check("x7_rs2", b_rs2, 32'h22);
        check("x7_dbg", b_dbg, 32'h22);
        check("x7_rs1_nb", n_rs1, 32'h22);
        check("x7_cnt", b_cnt, 32'd3);

        // Back-to-back writes: last edge wins, both counted; ports independent.
        we = 1'b1; rd_addr = 5'd9; rd_data = 32'h1;
        tick();
        rd_data = 32'h2;
        tick();
        we = 1'b0; rs1_addr = 5'd9; rs2_addr = 5'd5;
        #1;
        check("b2b_rs1", b_rs1, 32'h2);
        check("b2b_rs2", b_rs2, 32'hDEAD_BEEF);
        check("b2b_cnt", b_cnt, 32'd5);
        check("b2b_cnt_nb", n_cnt, 32'd5);

        // Reset beats a same-cycle write; forwarding still visible during reset.
        rst = 1'b1; we = 1'b1; rd_addr = 5'd3; rd_data = 32'hAA;
        rs1_addr = 5'd3; rs2_addr = 5'd5; dbg_addr = 5'd3;
        #1;
        check("rstwr_byp_rs1", b_rs1, 32'hAA);
        check("rstwr_nobyp_rs1", n_rs1, 32'h0);
        check("rstwr_dbg", b_dbg, 32'h0);
        tick();
        rst = 1'b0; we = 1'b0;
        #1;
        check("rstwr_x3", b_rs1, 32'h0);
        check("rstwr_x3_dbg", b_dbg, 32'h0);
        check("rstwr_x5", b_rs2, 32'h0);
        check("rstwr_cnt", b_cnt, 32'd0);

        // Counter wrap via backdoor preload.
        force u_byp.r_wr_count = 32'hFFFF_FFFF;
        #1;
        release u_byp.r_wr_count;
        #1;
        check("preload_cnt", b_cnt, 32'hFFFF_FFFF);
        we = 1'b1; rd_addr = 5'd1; rd_data = 32'h5; rs1_addr = 5'd1;
        tick();
        we = 1'b0;
        #1;
        check("wrap_cnt", b_cnt, 32'd0);
        check("wrap_x1", b_rs1, 32'h5);
        check("wrap_cnt_nb", n_cnt, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
